result_reader: RTL

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/result_reader.sv
// result_reader: reads a block of SRAM words and streams each word as two
// 16-bit beats (upper half first) over a valid/ready interface.
// Optional feature: define RESULT_READER_CHECKSUM_EN to build a running
// 16-bit checksum of emitted beats; otherwise checksum is tied to zero.
module result_reader #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              done,
  output logic              sram_REQ,
  output logic              sram_WRITEn,
  output logic [ADDR_W-1:0] sram_ADDR,
  input  logic [DATA_W-1:0] sram_RDATA,
  input  logic              sram_READY,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_data,
  output logic              out_last,
  output logic [15:0]       checksum
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ   = 3'd1,
    WAIT   = 3'd2,
    EMIT_A = 3'd3,
    EMIT_B = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] remaining;
  // Lower result of the captured word; the upper result goes straight to out_data.
  logic [15:0]       held_lo;

  // The block is read-only towards the SRAM.
  assign sram_WRITEn = 1'b1;

  // Control FSM; every output is registered alongside the state transition.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      sram_REQ  <= 1'b0;
      sram_ADDR <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= 16'd0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sram_ADDR <= base_addr;
            remaining <= word_count;
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state    <= READ;
              sram_REQ <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        READ: begin
          sram_REQ <= 1'b0;
          state    <= WAIT;
        end
        WAIT: begin
          if (sram_READY) begin
            held_lo   <= sram_RDATA[15:0];
            out_data  <= sram_RDATA[31:16];
            out_last  <= 1'b0;
            out_valid <= 1'b1;
            state     <= EMIT_A;
          end
        end
        EMIT_A: begin
          if (out_ready) begin
            out_data <= held_lo;
            out_last <= (remaining == ADDR_W'(1));
            state    <= EMIT_B;
          end
        end
        EMIT_B: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            // Natural modular wrap from the top address back to zero.
            sram_ADDR <= sram_ADDR + ADDR_W'(1);
            remaining <= remaining - ADDR_W'(1);
            if (remaining > ADDR_W'(1)) begin
              state    <= READ;
              sram_REQ <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
          sram_REQ  <= 1'b0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RESULT_READER_CHECKSUM_EN
  logic [15:0] checksum_acc;

  function automatic logic [15:0] add_mod16(input logic [15:0] a, input logic [15:0] b);
    return a + b;
  endfunction

  // Running sum of accepted beats, cleared when a new readback is accepted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      checksum_acc <= 16'd0;
    end else if (state == IDLE && start) begin
      checksum_acc <= 16'd0;
    end else if (out_valid && out_ready) begin
      checksum_acc <= add_mod16(checksum_acc, out_data);
    end
  end

  assign checksum = checksum_acc;
`else
  assign checksum = 16'd0;
`endif

endmodule
